load_store_unit: RTL and testbench

- Sits between the CPU execute stage and the byte-wide data port of the shared BRAM memory block.
- Turns one CPU load or store of byte or 16-bit word size into one or two sequenced single-byte memory transactions.
- Word accesses are little-endian; byte loads are sign- or zero-extended.
- Enforces the memory port's timing rules:
  - address is stable before the request;
  - the request is a one-cycle pulse;
  - a settle gap follows each write, so the memory's read-modify-write never reads stale data.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// default settle length and the load result formatter.
package lsu_pkg;

    localparam int LSU_SETTLE_CYCLES_DEFAULT = 1;

    typedef enum logic [2:0] {
        LSU_IDLE   = 3'd0,
        LSU_SETUP  = 3'd1,
        LSU_REQ    = 3'd2,
        LSU_WAIT   = 3'd3,
        LSU_SETTLE = 3'd4,
        LSU_DONE   = 3'd5
    } lsu_state_e;

    // raw holds {byte1, byte0} as read from memory (byte1 unused for byte loads)
    function automatic logic [15:0] load_format(input logic [15:0] raw,
                                                input logic        is_word,
                                                input logic        is_signed);
        logic [15:0] res;
        if (is_word) begin
            res = raw;
        end else if (is_signed) begin
            res = {{8{raw[7]}}, raw[7:0]};
        end else begin
            res = {8'h00, raw[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Sequences CPU byte/halfword loads and stores into single-byte BRAM port transactions.
// Optional macro LSU_MISALIGN_TRAP_EN: odd-address word accesses fault instead of splitting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int SETTLE_CYCLES = LSU_SETTLE_CYCLES_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lsu_req_i,
    input  logic              lsu_write_i,
    input  logic              lsu_word_i,
    input  logic              lsu_signed_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [15:0]       lsu_wdata_i,
    output logic [15:0]       lsu_rdata_o,
    output logic              lsu_done_o,
    output logic              lsu_busy_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              lsu_fault_o,
`endif
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_write_o,
    output logic              mem_req_o,
    input  logic              mem_done_i
);

    localparam int SETTLE_N = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W    = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_N - 1);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              word_q, word_d;
    logic              signed_q, signed_d;
    logic              idx_q, idx_d;
    logic              more_q, more_d;
    logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              more;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              fault_q, fault_d;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        word_d       = word_q;
        signed_d     = signed_q;
        idx_d        = idx_q;
        more_d       = more_q;
        settle_cnt_d = settle_cnt_q;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        more         = word_q && !idx_q;
`ifdef LSU_MISALIGN_TRAP_EN
        fault_d      = fault_q;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i) begin
                    addr_d      = lsu_addr_i;
                    wdata_d     = lsu_wdata_i;
                    write_d     = lsu_write_i;
                    word_d      = lsu_word_i;
                    signed_d    = lsu_signed_i;
                    idx_d       = 1'b0;
                    more_d      = 1'b0;
                    // Address/data are registered here so they are stable through SETUP
                    mem_addr_d  = lsu_addr_i;
                    mem_wdata_d = lsu_wdata_i[7:0];
                    if (!lsu_write_i) begin
                        rdata_d = '0;
                    end
                    state_d = LSU_SETUP;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (lsu_word_i && lsu_addr_i[0]) begin
                        rdata_d     = rdata_q;
                        mem_addr_d  = mem_addr_q;
                        mem_wdata_d = mem_wdata_q;
                        fault_d     = 1'b1;
                        state_d     = LSU_DONE;
                    end
`endif
                end
            end
            LSU_SETUP: state_d = LSU_REQ;
            LSU_REQ:   state_d = LSU_WAIT;
            LSU_WAIT: begin
                if (mem_done_i) begin
                    if (!write_q) begin
                        if (idx_q) begin
                            rdata_d[15:8] = mem_rdata_i;
                        end else begin
                            rdata_d[7:0] = mem_rdata_i;
                        end
                        if (!more) begin
                            rdata_d = load_format(rdata_d, word_q, signed_q);
                        end
                    end
                    // Advance to the second byte now so SETTLE already presents its address
                    if (more) begin
                        idx_d       = 1'b1;
                        mem_addr_d  = addr_q + ADDR_W'(1);
                        mem_wdata_d = wdata_q[15:8];
                    end
                    more_d = more;
                    if (write_q) begin
                        settle_cnt_d = '0;
                        state_d      = LSU_SETTLE;
                    end else begin
                        state_d = more ? LSU_SETUP : LSU_DONE;
                    end
                end
            end
            LSU_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = more_q ? LSU_SETUP : LSU_DONE;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                fault_d = 1'b0;
`endif
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= LSU_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            word_q       <= 1'b0;
            signed_q     <= 1'b0;
            idx_q        <= 1'b0;
            more_q       <= 1'b0;
            settle_cnt_q <= '0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            word_q       <= word_d;
            signed_q     <= signed_d;
            idx_q        <= idx_d;
            more_q       <= more_d;
            settle_cnt_q <= settle_cnt_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign lsu_rdata_o = rdata_q;
    assign lsu_done_o  = (state_q == LSU_DONE);
    assign lsu_busy_o  = (state_q != LSU_IDLE);
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_req_o   = (state_q == LSU_REQ);
    assign mem_write_o = (state_q == LSU_REQ) && write_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign lsu_fault_o = fault_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-memory responder of programmable latency.
// Builds with or without LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req, lsu_write, lsu_word, lsu_signed;
    logic [15:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        lsu_done, lsu_busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_write, mem_req;
    logic        mem_done = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        lsu_fault;
`endif

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(16), .SETTLE_CYCLES(1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .lsu_req_i    (lsu_req),
        .lsu_write_i  (lsu_write),
        .lsu_word_i   (lsu_word),
        .lsu_signed_i (lsu_signed),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_rdata_o  (lsu_rdata),
        .lsu_done_o   (lsu_done),
        .lsu_busy_o   (lsu_busy),
`ifdef LSU_MISALIGN_TRAP_EN
        .lsu_fault_o  (lsu_fault),
`endif
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_write_o  (mem_write),
        .mem_req_o    (mem_req),
        .mem_done_i   (mem_done)
    );

    typedef struct {
        string       name;
        logic [15:0] rdata;
        bit          chk_rdata;
        int          accept_cyc;
        int          lat;
        logic        fault;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [7:0]  mem [0:65535];
    int          resp_delay = 0;
    bit          pend       = 1'b0;
    int          pend_cnt   = 0;
    logic [15:0] pend_addr  = 16'h0;
    bit          prev_req   = 1'b0;
    int          req_times[$];
    logic [15:0] req_addrs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: sees mem_req mid-cycle, answers mem_done resp_delay cycles after WAIT begins
    always @(negedge clk) begin
        if (!rst_n) begin
            pend     = 1'b0;
            mem_done = 1'b0;
            prev_req = 1'b0;
        end else begin
            mem_done = 1'b0;
            if (pend) begin
                check("mem_addr_stable", 32'(mem_addr), 32'(pend_addr));
                if (pend_cnt == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = mem[pend_addr];
                    pend      = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (mem_req) begin
                check("req_single_cycle", 32'(prev_req), 32'h0);
                if (mem_write) mem[mem_addr] = mem_wdata;
                pend      = 1'b1;
                pend_cnt  = resp_delay;
                pend_addr = mem_addr;
                req_times.push_back(cyc);
                req_addrs.push_back(mem_addr);
            end
            prev_req = mem_req;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && lsu_done) begin
            check("done_expected", 32'(sb_q.size() > 0), 32'h1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, " latency"}, 32'(cyc - mon_e.accept_cyc), 32'(mon_e.lat));
                if (mon_e.chk_rdata)
                    check({mon_e.name, " rdata"}, 32'(lsu_rdata), 32'(mon_e.rdata));
`ifdef LSU_MISALIGN_TRAP_EN
                check({mon_e.name, " fault"}, 32'(lsu_fault), 32'(mon_e.fault));
`endif
                $display("txn %s: rdata=0x%04h latency=%0d", mon_e.name, lsu_rdata, cyc - mon_e.accept_cyc);
            end
        end
    end

    task automatic do_op(input string name, input logic wr, input logic wd, input logic sg,
                         input logic [15:0] addr, input logic [15:0] wdat,
                         input bit chk, input logic [15:0] exp_rd,
                         input int lat, input logic flt, input bit poke);
        exp_t e;
        bit   seen;
        int   i;
        @(negedge clk);
        lsu_req    = 1'b1;
        lsu_write  = wr;
        lsu_word   = wd;
        lsu_signed = sg;
        lsu_addr   = addr;
        lsu_wdata  = wdat;
        e.name       = name;
        e.rdata      = exp_rd;
        e.chk_rdata  = chk;
        e.accept_cyc = cyc;
        e.lat        = lat;
        e.fault      = flt;
        sb_q.push_back(e);
        @(negedge clk);
        lsu_req = 1'b0;
        check({name, " busy"}, 32'(lsu_busy), 32'h1);
        seen = lsu_done;
        i    = 0;
        while (!seen && i < 60) begin
            @(negedge clk);
            i++;
            if (poke) begin
                if (i == 2 || i == 5) begin
                    lsu_req   = 1'b1;
                    lsu_write = 1'b1;
                    lsu_addr  = 16'h0077;
                end else begin
                    lsu_req = 1'b0;
                end
            end
            seen = lsu_done;
        end
        lsu_req = 1'b0;
        check({name, " done_seen"}, 32'(seen), 32'h1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int i;
        rst_n      = 1'b0;
        lsu_req    = 1'b0;
        lsu_write  = 1'b0;
        lsu_word   = 1'b0;
        lsu_signed = 1'b0;
        lsu_addr   = 16'h0;
        lsu_wdata  = 16'h0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        repeat (3) @(negedge clk);
        check("reset rdata", 32'(lsu_rdata), 32'h0);
        check("reset busy", 32'(lsu_busy), 32'h0);
        check("reset done", 32'(lsu_done), 32'h0);
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        check("reset mem_wdata", 32'(mem_wdata), 32'h0);
        check("reset mem_req", 32'(mem_req), 32'h0);
        check("reset mem_write", 32'(mem_write), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", 32'(lsu_busy), 32'h0);

        do_op("st_byte",   1'b1, 1'b0, 1'b0, 16'h0010, 16'h00A5, 1'b0, 16'h0000, 5, 1'b0, 1'b0);
        check("mem_0010", 32'(mem[16'h0010]), 32'hA5);
        do_op("ld_byte_u", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h00A5, 4, 1'b0, 1'b0);
        do_op("ld_byte_s", 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'hFFA5, 4, 1'b0, 1'b0);

        n0 = req_times.size();
        do_op("st_word",   1'b1, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 1'b0, 16'h0000, 9, 1'b0, 1'b0);
        check("st_word req_count", 32'(req_times.size() - n0), 32'h2);
        if (req_times.size() >= n0 + 2)
            check("settle_gap", 32'(req_times[n0+1] - req_times[n0]), 32'h4);
        check("mem_0020", 32'(mem[16'h0020]), 32'hEF);
        check("mem_0021", 32'(mem[16'h0021]), 32'hBE);
        do_op("ld_word",   1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'hBEEF, 7, 1'b0, 1'b0);

        n0 = req_times.size();
`ifdef LSU_MISALIGN_TRAP_EN
        do_op("st_word_odd",  1'b1, 1'b1, 1'b0, 16'h0031, 16'h1234, 1'b0, 16'h0000, 1, 1'b1, 1'b0);
        do_op("ld_word_odd",  1'b0, 1'b1, 1'b0, 16'h0031, 16'h0000, 1'b1, 16'hBEEF, 1, 1'b1, 1'b0);
        do_op("ld_word_ffff", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'hBEEF, 1, 1'b1, 1'b0);
        check("trap no_req", 32'(req_times.size() - n0), 32'h0);
`else
        do_op("st_word_odd",  1'b1, 1'b1, 1'b0, 16'h0031, 16'h1234, 1'b0, 16'h0000, 9, 1'b0, 1'b0);
        check("mem_0031", 32'(mem[16'h0031]), 32'h34);
        check("mem_0032", 32'(mem[16'h0032]), 32'h12);
        do_op("ld_word_odd",  1'b0, 1'b1, 1'b0, 16'h0031, 16'h0000, 1'b1, 16'h1234, 7, 1'b0, 1'b0);
        n0 = req_times.size();
        do_op("ld_word_ffff", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h2211, 7, 1'b0, 1'b0);
        check("ffff req_count", 32'(req_times.size() - n0), 32'h2);
        if (req_times.size() >= n0 + 2) begin
            check("ffff addr0", 32'(req_addrs[n0]), 32'hFFFF);
            check("ffff addr1", 32'(req_addrs[n0+1]), 32'h0000);
        end
`endif

        // Slow memory plus ignored requests while busy
        resp_delay = 3;
        n0 = req_times.size();
        do_op("ld_word_slow", 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'hBEEF, 13, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("ignored_req busy", 32'(lsu_busy), 32'h0);
        end
        check("slow req_count", 32'(req_times.size() - n0), 32'h2);

        // Asynchronous reset in the middle of a word store
        n0 = req_times.size();
        @(negedge clk);
        lsu_req   = 1'b1;
        lsu_write = 1'b1;
        lsu_word  = 1'b1;
        lsu_addr  = 16'h0040;
        lsu_wdata = 16'h5678;
        @(negedge clk);
        lsu_req = 1'b0;
        i = 0;
        while (req_times.size() == n0 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("rst_test req_seen", 32'(req_times.size() > n0), 32'h1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst rdata", 32'(lsu_rdata), 32'h0);
        check("async_rst busy", 32'(lsu_busy), 32'h0);
        check("async_rst done", 32'(lsu_done), 32'h0);
        check("async_rst mem_addr", 32'(mem_addr), 32'h0);
        check("async_rst mem_wdata", 32'(mem_wdata), 32'h0);
        check("async_rst mem_req", 32'(mem_req), 32'h0);
        check("async_rst mem_write", 32'(mem_write), 32'h0);
        resp_delay = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        do_op("ld_after_rst", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h00A5, 4, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
